// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and single-outstanding imem fetcher feeding IF/ID; optional FETCH_PERF_EN counters
module fetch_stage #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int PC_INC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_plus2_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pend, pend_n, hold_pc, hold_pc_n, pc_inc, rpc;
  logic [INSTR_W-1:0] hold_ins, hold_ins_n;
  logic req, wr, flush;
  assign pc_inc = pc + ADDR_W'(PC_INC);
  assign rpc = redirect_pc & ~ADDR_W'(1);
  // state, PC, pending redirect target and hold buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      pend <= '0;
      hold_pc <= '0;
      hold_ins <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      pend <= pend_n;
      hold_pc <= hold_pc_n;
      hold_ins <= hold_ins_n;
    end
  end
  // next-state and handshake decode; redirect outranks stall
  always_comb begin
    state_n = state;
    pc_n = pc;
    pend_n = pend;
    hold_pc_n = hold_pc;
    hold_ins_n = hold_ins;
    req = 1'b0;
    wr = 1'b0;
    flush = redirect && state != IDLE;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        req = 1'b1;
        if (imem_ready) begin
          if (redirect) pc_n = rpc;
          else begin
            pc_n = pc_inc;
            if (stall) begin
              hold_pc_n = pc_inc;
              hold_ins_n = imem_rdata;
              state_n = HOLD;
            end else wr = 1'b1;
          end
        end else if (redirect) begin
          pend_n = rpc;
          state_n = DISCARD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n = rpc;
          state_n = FETCH;
        end else if (!stall) begin
          wr = 1'b1;
          state_n = FETCH;
        end
      end
      default: begin
        req = 1'b1;
        if (redirect) pend_n = rpc;
        if (imem_ready) begin
          pc_n = redirect ? rpc : pend;
          state_n = FETCH;
        end
      end
    endcase
  end
  assign imem_req = rst & req;
  assign imem_addr = rst ? pc : '0;
  assign if_id_write = rst & wr;
  assign if_id_flush = rst & flush;
  assign pc_plus2_out = !rst ? '0 : state == HOLD ? hold_pc : pc_inc;
  assign instr_out = !rst ? '0 : state == HOLD ? hold_ins : imem_rdata;
`ifdef FETCH_PERF_EN
  logic [31:0] fcnt, scnt;
  // saturating delivered-instruction and stalled-cycle counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      fcnt <= '0;
      scnt <= '0;
    end else begin
      if (if_id_write && fcnt != '1) fcnt <= fcnt + 32'd1;
      if (stall && state != IDLE && scnt != '1) scnt <= scnt + 32'd1;
    end
  end
  assign fetch_count = rst ? fcnt : '0;
  assign stall_count = rst ? scnt : '0;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0, rst, stall, redirect, imem_ready, imem_req, if_id_write, if_id_flush;
  logic [15:0] redirect_pc, imem_addr, imem_rdata, pc_plus2_out, instr_out;
  logic [31:0] fetch_count, stall_count;
  int errors = 0, checks = 0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .pc_plus2_out(pc_plus2_out), .instr_out(instr_out), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .fetch_count(fetch_count), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic st, input logic rd, input logic [15:0] rp,
                      input logic rdy, input logic [15:0] d);
    @(negedge clk);
    rst = r; stall = st; redirect = rd; redirect_pc = rp; imem_ready = rdy; imem_rdata = d;
    #1;
  endtask
  task automatic fetch_chk(input string tag, input logic q, input logic [15:0] a, input logic w);
    check({tag, "_req"}, 32'(imem_req), 32'(q));
    if (q) check({tag, "_addr"}, 32'(imem_addr), 32'(a));
    check({tag, "_write"}, 32'(if_id_write), 32'(w));
  endtask
  task automatic zero_chk(input string tag);
    check({tag, "_req"}, 32'(imem_req), 0);
    check({tag, "_addr"}, 32'(imem_addr), 0);
    check({tag, "_write"}, 32'(if_id_write), 0);
    check({tag, "_flush"}, 32'(if_id_flush), 0);
    check({tag, "_pc2"}, 32'(pc_plus2_out), 0);
    check({tag, "_instr"}, 32'(instr_out), 0);
    check({tag, "_fcnt"}, fetch_count, 0);
    check({tag, "_scnt"}, stall_count, 0);
  endtask
  task automatic cnt_chk(input string tag, input int f, input int s);
`ifdef FETCH_PERF_EN
    check({tag, "_fcnt"}, fetch_count, 32'(f));
    check({tag, "_scnt"}, stall_count, 32'(s));
`else
    check({tag, "_fcnt"}, fetch_count, 32'(f & 0));
    check({tag, "_scnt"}, stall_count, 32'(s & 0));
`endif
  endtask
  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0; imem_rdata = 16'h1111;
    step(0, 0, 1, 16'h4444, 1, 16'habab);
    zero_chk("rst_a");
    step(1, 0, 0, 0, 1, 16'habab);
    fetch_chk("idle", 0, 0, 0);
    check("idle_flush", 32'(if_id_flush), 0);
    step(1, 0, 0, 0, 1, 16'habab);
    fetch_chk("f0", 1, 16'h0000, 1);
    check("f0_pc2", 32'(pc_plus2_out), 32'h0002);
    check("f0_instr", 32'(instr_out), 32'habab);
    step(1, 0, 0, 0, 1, 16'habab);
    fetch_chk("f1", 1, 16'h0002, 1);
    check("f1_pc2", 32'(pc_plus2_out), 32'h0004);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 16'h7777);
      fetch_chk("wait", 1, 16'h0004, 0);
    end
    step(1, 0, 0, 0, 1, 16'habab);
    fetch_chk("f2", 1, 16'h0004, 1);
    check("f2_pc2", 32'(pc_plus2_out), 32'h0006);
    step(1, 1, 0, 0, 1, 16'hdddd);
    fetch_chk("stall_rsp", 1, 16'h0006, 0);
    step(1, 1, 0, 0, 0, 16'h0000);
    fetch_chk("hold0", 0, 0, 0);
    check("hold0_instr", 32'(instr_out), 32'hdddd);
    check("hold0_pc2", 32'(pc_plus2_out), 32'h0008);
    step(1, 0, 0, 0, 0, 16'h0000);
    fetch_chk("hold1", 0, 0, 1);
    check("hold1_instr", 32'(instr_out), 32'hdddd);
    check("hold1_pc2", 32'(pc_plus2_out), 32'h0008);
    step(1, 0, 1, 16'h1279, 0, 16'h0000);
    fetch_chk("redir", 1, 16'h0008, 0);
    check("redir_flush", 32'(if_id_flush), 1);
    step(1, 0, 0, 0, 1, 16'hbeef);
    fetch_chk("discard", 1, 16'h0008, 0);
    check("discard_flush", 32'(if_id_flush), 0);
    step(1, 0, 0, 0, 0, 16'h0000);
    fetch_chk("tgt", 1, 16'h1278, 0);
    step(1, 0, 1, 16'hfffe, 1, 16'h9999);
    fetch_chk("redir2", 1, 16'h1278, 0);
    check("redir2_flush", 32'(if_id_flush), 1);
    step(1, 0, 0, 0, 1, 16'h1234);
    fetch_chk("wrap0", 1, 16'hfffe, 1);
    check("wrap0_pc2", 32'(pc_plus2_out), 32'h0000);
    check("wrap0_instr", 32'(instr_out), 32'h1234);
    step(1, 0, 0, 0, 1, 16'h5678);
    fetch_chk("wrap1", 1, 16'h0000, 1);
    check("wrap1_pc2", 32'(pc_plus2_out), 32'h0002);
    cnt_chk("mid", 5, 2);
    step(1, 1, 0, 0, 1, 16'h5555);
    fetch_chk("stall2", 1, 16'h0002, 0);
    step(1, 1, 0, 0, 0, 16'h0000);
    fetch_chk("hold2", 0, 0, 0);
    cnt_chk("hold2", 6, 3);
    step(0, 1, 0, 0, 0, 16'h0000);
    zero_chk("rst_b");
    step(1, 0, 0, 0, 1, 16'hcafe);
    fetch_chk("idle2", 0, 0, 0);
    cnt_chk("cleared", 0, 0);
    step(1, 0, 0, 0, 1, 16'hcafe);
    fetch_chk("restart", 1, 16'h0000, 1);
    check("restart_pc2", 32'(pc_plus2_out), 32'h0002);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
